// File: rtl/scomp_pkg.sv
// scomp_pkg: run-state encodings shared by the run controller and status/LED logic.
package scomp_pkg;
  typedef enum logic [1:0] {
    ST_HALT  = 2'd0,
    ST_RUN   = 2'd1,
    ST_BREAK = 2'd2
  } run_state_t;
endpackage

// File: rtl/key_debounce.sv
// key_debounce: synchronises a raw pushbutton, debounces it on sample ticks and pulses on press.
module key_debounce #(
  parameter int DB_SAMPLES     = 3,
  parameter bit KEY_ACTIVE_LOW = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_key,
  input  logic i_tick,
  output logic o_press
);
  localparam int CW = $clog2(DB_SAMPLES + 1);
  localparam logic REL = KEY_ACTIVE_LOW;
  logic [1:0]    r_sync;
  logic          r_lvl;
  logic [CW-1:0] r_cnt;
  logic          r_press;
  logic          w_smp;
  logic          w_flip;
  assign w_smp  = KEY_ACTIVE_LOW ? ~r_sync[1] : r_sync[1];
  // the sample that would complete the run of disagreeing samples flips the level
  assign w_flip = i_tick && (w_smp != r_lvl) && (r_cnt == CW'(DB_SAMPLES - 1));
  assign o_press = r_press;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync  <= {2{REL}};
      r_lvl   <= 1'b0;
      r_cnt   <= '0;
      r_press <= 1'b0;
    end else begin
      r_sync  <= {r_sync[0], i_key};
      r_press <= w_flip & w_smp;
      if (i_tick) begin
        r_lvl <= w_flip ? w_smp : r_lvl;
        r_cnt <= (w_smp == r_lvl || w_flip) ? '0 : r_cnt + 1'b1;
      end
    end
  end
endmodule

// File: rtl/scomp_run_ctrl.sv
// scomp_run_ctrl: run/step/breakpoint sequencer issuing single-cycle cpu_en pulses
// for the scomp core from a fast/slow tick, a debounced step key and a PC breakpoint.
module scomp_run_ctrl
  import scomp_pkg::*;
#(
  parameter int CLK_HZ         = 50000000,
  parameter int FAST_HZ        = 100,
  parameter int SLOW_HZ        = 10,
  parameter int DB_SAMPLES     = 3,
  parameter bit KEY_ACTIVE_LOW = 1'b1
) (
  input  logic        clk,
  input  logic        reset_key,
  input  logic        key_step,
  input  logic        mode_step,
  input  logic        rate_slow,
  input  logic [7:0]  pc,
  input  logic [7:0]  bp_addr,
  input  logic        bp_en,
  output logic        cpu_en,
  output logic [1:0]  run_state,
  output logic [15:0] en_count
);
  localparam int DIV_F = CLK_HZ / FAST_HZ;
  localparam int DIV_S = FAST_HZ / SLOW_HZ;
  localparam int PW    = $clog2(DIV_F);
  localparam int SW    = $clog2(DIV_S);
  logic [PW-1:0] r_pre;
  logic [SW-1:0] r_slow;
  logic [1:0]    r_mode_sync;
  logic [1:0]    r_rate_sync;
  logic          r_en;
  logic [15:0]   r_cnt;
  run_state_t    r_state;
  run_state_t    w_nstate;
  logic          w_pulse;
  logic          w_tick_fast;
  logic          w_tick_slow;
  logic          w_tick_run;
  logic          w_press;
  logic          w_mode;
  logic          w_bp_hit;
  assign w_tick_fast = r_pre == PW'(DIV_F - 1);
  assign w_tick_slow = w_tick_fast && (r_slow == SW'(DIV_S - 1));
  assign w_tick_run  = r_rate_sync[1] ? w_tick_slow : w_tick_fast;
  assign w_mode      = r_mode_sync[1];
  assign w_bp_hit    = bp_en && (pc == bp_addr);
  assign cpu_en      = r_en;
  assign run_state   = r_state;
  assign en_count    = r_cnt;
  key_debounce #(
    .DB_SAMPLES(DB_SAMPLES),
    .KEY_ACTIVE_LOW(KEY_ACTIVE_LOW)
  ) u_key (
    .clk(clk),
    .rst_n(reset_key),
    .i_key(key_step),
    .i_tick(w_tick_fast),
    .o_press(w_press)
  );
  always_ff @(posedge clk or negedge reset_key) begin
    if (!reset_key) begin
      r_pre       <= '0;
      r_slow      <= '0;
      r_mode_sync <= '0;
      r_rate_sync <= '0;
      r_en        <= 1'b0;
      r_cnt       <= '0;
    end else begin
      r_pre       <= w_tick_fast ? '0 : r_pre + 1'b1;
      if (w_tick_fast) r_slow <= w_tick_slow ? '0 : r_slow + 1'b1;
      r_mode_sync <= {r_mode_sync[0], mode_step};
      r_rate_sync <= {r_rate_sync[0], rate_slow};
      // back-to-back guard keeps cpu_en a strict single-cycle pulse
      r_en        <= w_pulse & ~r_en;
      r_cnt       <= r_cnt + 16'(r_en);
    end
  end
  always_ff @(posedge clk or negedge reset_key) begin
    if (!reset_key) r_state <= ST_HALT;
    else r_state <= w_nstate;
  end
  always_comb begin
    w_nstate = r_state;
    w_pulse  = 1'b0;
    case (r_state)
      ST_HALT: begin
        if (!w_mode) w_nstate = ST_RUN;
        else if (w_press) w_pulse = 1'b1;
      end
      ST_RUN: begin
        if (w_mode) w_nstate = ST_HALT;
        else if (w_tick_run && w_bp_hit) w_nstate = ST_BREAK;
        else if (w_tick_run) w_pulse = 1'b1;
      end
      ST_BREAK: begin
        if (w_press) begin
          w_pulse  = 1'b1;
          w_nstate = w_mode ? ST_HALT : ST_RUN;
        end
      end
      default: w_nstate = ST_HALT;
    endcase
  end
endmodule

// File: tb/tb_scomp_run_ctrl.sv
// tb_scomp_run_ctrl: randomized self-checking bench; expectations come from tick-grid
// arithmetic (pulses on multiples of 10/100 clk after reset) and pulse/pc bookkeeping.
module tb_scomp_run_ctrl;
  logic        clk = 1'b0;
  logic        reset_key, key_step, mode_step, rate_slow, bp_en;
  logic [7:0]  pc, bp_addr;
  logic        cpu_en;
  logic [1:0]  run_state;
  logic [15:0] en_count;
  int n_chk = 0, n_fail = 0;
  int cyc = 0, n_total = 0, last_pulse = 0, grid = 0;
  bit prev_en = 1'b0, pc_track = 1'b0;

  scomp_run_ctrl #(
    .CLK_HZ(1000), .FAST_HZ(100), .SLOW_HZ(10), .DB_SAMPLES(3), .KEY_ACTIVE_LOW(1'b1)
  ) dut (
    .clk(clk), .reset_key(reset_key), .key_step(key_step), .mode_step(mode_step),
    .rate_slow(rate_slow), .pc(pc), .bp_addr(bp_addr), .bp_en(bp_en),
    .cpu_en(cpu_en), .run_state(run_state), .en_count(en_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cyc %0d)", tag, act, exp, cyc);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  always @(posedge clk or negedge reset_key)
    if (!reset_key) cyc <= 0;
    else cyc <= cyc + 1;

  // pulse monitor: spacing, count bookkeeping and the pc model
  always @(negedge clk) begin
    if (!reset_key) begin
      n_total = 0;
      prev_en = 1'b0;
    end else begin
      if (cpu_en) begin
        chk("no_back2back", int'(prev_en), 0);
        chk("en_count", int'(en_count), n_total);
        if (grid != 0) chk("tick_grid", cyc % grid, 0);
        if (pc_track) pc = pc + 8'd1;
        last_pulse = cyc;
        n_total++;
      end
      prev_en = cpu_en;
    end
  end

  initial begin
    int n0, nb, tp, bp;
    bit found;
    reset_key = 1'b0; key_step = 1'b1; mode_step = 1'b0; rate_slow = 1'b0;
    pc = 8'd0; bp_addr = 8'd0; bp_en = 1'b0;
    cycles(3);
    chk("rst_cpu_en", int'(cpu_en), 0);
    chk("rst_state", int'(run_state), 0);
    chk("rst_count", int'(en_count), 0);
    @(negedge clk);
    reset_key = 1'b1;
    // fast free-run: pulses after edges 10,20,...; 99 completed by edge 1000
    grid = 10;
    cycles(1000);
    chk("run_state_run", int'(run_state), 1);
    chk("fast_pulses", n_total, 99);
    chk("fast_en_count", int'(en_count), 99);
    grid = 0;
    // slow free-run over a 1000-edge window: exactly ten 100-clk grid points
    rate_slow = 1'b1;
    cycles($urandom_range(20, 60));
    grid = 100;
    n0 = n_total;
    cycles(1000);
    chk("slow_pulses", n_total - n0, 10);
    grid = 0;
    // step mode with a clean press
    mode_step = 1'b1;
    cycles(5);
    chk("halt_state", int'(run_state), 0);
    n0 = n_total;
    cycles($urandom_range(0, 20));
    key_step = 1'b0;
    tp = cyc;
    cycles(60);
    key_step = 1'b1;
    cycles(60);
    chk("step_pulses", n_total - n0, 1);
    chk("step_latency_ok", int'((last_pulse - tp) >= 20 && (last_pulse - tp) <= 40), 1);
    chk("still_halt", int'(run_state), 0);
    // bouncing key, then stable press
    cycles($urandom_range(0, 20));
    n0 = n_total;
    for (int i = 0; i < 50; i++) begin
      key_step = ((i / 7) % 2) ? 1'b1 : 1'b0;
      cycles(1);
    end
    chk("bounce_no_pulse", n_total - n0, 0);
    key_step = 1'b0;
    cycles(60);
    key_step = 1'b1;
    cycles(60);
    chk("bounce_press_pulses", n_total - n0, 1);
    // breakpoint in run mode with pc advancing once per pulse
    bp = $urandom_range(2, 7);
    bp_addr = 8'(bp);
    bp_en = 1'b1;
    pc = 8'd0;
    rate_slow = 1'b0;
    pc_track = 1'b1;
    n0 = n_total;
    mode_step = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 2000 && !found; i++) begin
      cycles(1);
      found = (run_state == 2'd2);
    end
    chk("break_reached", int'(found), 1);
    chk("pulses_before_bp", n_total - n0, bp);
    chk("pc_at_bp", int'(pc), bp);
    nb = n_total;
    cycles(500);
    chk("break_holds", n_total - nb, 0);
    chk("break_state", int'(run_state), 2);
    key_step = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      cycles(1);
      found = (run_state == 2'd1);
    end
    chk("break_resume", int'(found), 1);
    cycles(1);
    chk("break_step_pulse", n_total - nb, 1);
    chk("pc_past_bp", int'(pc), bp + 1);
    key_step = 1'b1;
    n0 = n_total;
    cycles(60);
    chk("resumed_pulses", n_total - n0, 6);
    // asynchronous reset in the middle of a pulse
    pc_track = 1'b0;
    bp_en = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 30 && !found; i++) begin
      cycles(1);
      found = cpu_en;
    end
    chk("pulse_before_reset", int'(found), 1);
    #2 reset_key = 1'b0;
    #1;
    chk("mid_rst_cpu_en", int'(cpu_en), 0);
    chk("mid_rst_count", int'(en_count), 0);
    chk("mid_rst_state", int'(run_state), 0);
    repeat (2) @(negedge clk);
    reset_key = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 3 && !found; i++) begin
      cycles(1);
      found = (run_state == 2'd1);
    end
    chk("run_after_reset", int'(found), 1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
